// File: rtl/crop_window_ctrl.sv
// Frame-level controller for the boundary-crop stage: measures frame geometry from the
// vs/de stream, locks after two matching frames and drives registered crop window bounds.
module crop_window_ctrl #(
  parameter int CNT_BITS      = 12,
  parameter int DEF_SKIP_ROWS = 3,
  parameter int DEF_SKIP_COLS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                vs_i,
  input  logic                hs_i,
  input  logic                de_i,
  input  logic                cfg_we_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [CNT_BITS-1:0] cfg_wdata_i,
  output logic [CNT_BITS-1:0] col_lo_o,
  output logic [CNT_BITS-1:0] col_hi_o,
  output logic [CNT_BITS-1:0] row_lo_o,
  output logic [CNT_BITS-1:0] row_hi_o,
  output logic                crop_en_o,
  output logic                locked_o,
  output logic                cfg_err_o,
  output logic [CNT_BITS-1:0] meas_w_o,
  output logic [CNT_BITS-1:0] meas_h_o,
  output logic [7:0]          lost_cnt_o,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_VERIFY, S_LOCK} state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] DEF_C   = CNT_BITS'(DEF_SKIP_COLS);
  localparam logic [CNT_BITS-1:0] DEF_R   = CNT_BITS'(DEF_SKIP_ROWS);

  state_t              state;
  logic                vs_q, de_q, vs_rise, de_fall;
  logic [CNT_BITS-1:0] wcnt, hcnt, line_w, ref_w, ref_h;
  logic                first_line, line_err;
  logic                pending, commit;
  // Margin index: 0=left, 1=right, 2=top, 3=bottom.
  logic [CNT_BITS-1:0] sh_mar  [4];
  logic [CNT_BITS-1:0] act_mar [4];
  logic [CNT_BITS-1:0] mar_n   [4];
  logic                frame_good, frame_match, lock_n, err_n, en_n;
  logic [CNT_BITS-1:0] meas_w_n, meas_h_n;
  logic [CNT_BITS:0]   sum_lr, sum_tb, col_hi_x, row_hi_x;
  logic                unused_ok;

  assign vs_rise   = vs_i & ~vs_q;
  assign de_fall   = ~de_i & de_q;
  assign commit    = vs_rise & pending;
  assign state_o   = state;
  assign unused_ok = ^{hs_i, col_hi_x[CNT_BITS], row_hi_x[CNT_BITS]};

  // Geometry measurement: per-line width and per-frame line count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      wcnt       <= '0;
      hcnt       <= '0;
      line_w     <= '0;
      first_line <= 1'b1;
      line_err   <= 1'b0;
    end else begin
      vs_q <= vs_i;
      de_q <= de_i;
      if (!de_i)
        wcnt <= '0;
      else if (wcnt != CNT_MAX)
        wcnt <= wcnt + 1'b1;
      if (vs_rise) begin
        hcnt       <= '0;
        first_line <= 1'b1;
        line_err   <= 1'b0;
      end else if (de_fall) begin
        if (hcnt != CNT_MAX)
          hcnt <= hcnt + 1'b1;
        first_line <= 1'b0;
        if (first_line)
          line_w <= wcnt;
        else if (wcnt != line_w)
          line_err <= 1'b1;
      end
    end
  end

  // Shadow margins; a write landing on the vs_rise edge stays pending for the next frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_mar[0]  <= DEF_C;
      sh_mar[1]  <= DEF_C;
      sh_mar[2]  <= DEF_R;
      sh_mar[3]  <= DEF_R;
      act_mar[0] <= DEF_C;
      act_mar[1] <= DEF_C;
      act_mar[2] <= DEF_R;
      act_mar[3] <= DEF_R;
      pending    <= 1'b0;
    end else begin
      if (commit) begin
        for (int i = 0; i < 4; i++)
          act_mar[i] <= sh_mar[i];
      end
      if (cfg_we_i)
        sh_mar[cfg_addr_i] <= cfg_wdata_i;
      if (cfg_we_i)
        pending <= 1'b1;
      else if (vs_rise)
        pending <= 1'b0;
    end
  end

  // Next-frame view: lock, geometry and margins as they will be after this vs_rise.
  always_comb begin
    for (int i = 0; i < 4; i++)
      mar_n[i] = commit ? sh_mar[i] : act_mar[i];
    frame_good  = (hcnt != '0) && !line_err;
    frame_match = frame_good && (line_w == ref_w) && (hcnt == ref_h);
    lock_n      = locked_o;
    meas_w_n    = meas_w_o;
    meas_h_n    = meas_h_o;
    if (state == S_VERIFY && frame_match) begin
      lock_n   = 1'b1;
      meas_w_n = ref_w;
      meas_h_n = ref_h;
    end else if (state == S_LOCK && !frame_match) begin
      lock_n = 1'b0;
    end
    sum_lr   = {1'b0, mar_n[0]} + {1'b0, mar_n[1]};
    sum_tb   = {1'b0, mar_n[2]} + {1'b0, mar_n[3]};
    err_n    = lock_n && ((sum_lr >= {1'b0, meas_w_n}) || (sum_tb >= {1'b0, meas_h_n}));
    en_n     = lock_n && !err_n;
    col_hi_x = {1'b0, meas_w_n} - {1'b0, mar_n[1]};
    row_hi_x = {1'b0, meas_h_n} - {1'b0, mar_n[3]};
  end

  // Lock FSM and all crop outputs advance only on vs_rise; bounds freeze while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      ref_w      <= '0;
      ref_h      <= '0;
      locked_o   <= 1'b0;
      meas_w_o   <= '0;
      meas_h_o   <= '0;
      lost_cnt_o <= '0;
      cfg_err_o  <= 1'b0;
      crop_en_o  <= 1'b0;
      col_lo_o   <= '0;
      col_hi_o   <= '0;
      row_lo_o   <= '0;
      row_hi_o   <= '0;
    end else if (vs_rise) begin
      case (state)
        S_IDLE: state <= S_ACQ;
        S_ACQ: begin
          if (frame_good) begin
            ref_w <= line_w;
            ref_h <= hcnt;
            state <= S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (frame_match) begin
            state <= S_LOCK;
          end else if (frame_good) begin
            ref_w <= line_w;
            ref_h <= hcnt;
          end else begin
            state <= S_ACQ;
          end
        end
        S_LOCK: begin
          if (!frame_match) begin
            state <= S_ACQ;
            if (lost_cnt_o != 8'hFF)
              lost_cnt_o <= lost_cnt_o + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
      locked_o  <= lock_n;
      meas_w_o  <= meas_w_n;
      meas_h_o  <= meas_h_n;
      cfg_err_o <= err_n;
      crop_en_o <= en_n;
      if (en_n) begin
        col_lo_o <= mar_n[0];
        col_hi_o <= col_hi_x[CNT_BITS-1:0];
        row_lo_o <= mar_n[2];
        row_hi_o <= row_hi_x[CNT_BITS-1:0];
      end
    end
  end

endmodule
